laser_tx_sequencer: RTL and testbench
=====================================

# laser_tx_sequencer

Packet-level controller for the dual-lane laser transmitter. Buffers a fixed-size packet from the host byte stream and splits it across the two laser lanes as byte pairs. Frames each packet with a header and an optional checksum, then feeds the transmitter one frame at a time using its ready/done handshake. After sending, waits for a receiver-side acknowledgement and retransmits on timeout.

## Interface
Parameters:
- PKT_PAIRS, 16: payload frames per packet; each frame is 2 bytes, so the buffer holds 2*PKT_PAIRS bytes.
- TIMEOUT_CYCLES, 4096: clock cycles spent in ACK_WAIT before a timeout.
- MAX_RETRY, 3: number of retransmissions allowed before the packet is dropped.
- SOP, 8'hA5: start-of-packet marker byte.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  host payload byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- tx_data1  out  8  lane-1 byte for the transmitter.
- tx_data2  out  8  lane-2 byte for the transmitter.
- tx_ready  out  1  one-cycle load strobe; drives both transmitter data_ready inputs.
- tx_done  in  1  transmitter frame-complete pulse.
- tx_en  out  1  laser enable.
- ack_valid  in  1  acknowledgement decoded by the receive path.
- ack_seq  in  8  sequence number carried by the acknowledgement.
- seq  out  8  sequence number of the current packet.
- busy  out  1  high in every state except FILL.
- pkt_sent  out  1  one-cycle pulse: packet acknowledged.
- pkt_failed  out  1  one-cycle pulse: packet dropped after retries.

## Operation
- States: FILL, ISSUE, WAIT_DONE, ACK_WAIT.
- FILL:
  - in_ready=1.
  - Accepted bytes (in_valid&&in_ready) are written to buffer[wr_idx], and wr_idx increments.
  - When the byte at wr_idx=2*PKT_PAIRS-1 is accepted, frame_idx=0 and the next state is ISSUE.
- Frame contents, indexed by frame_idx:
  - Frame 0: {tx_data1, tx_data2} = {SOP, seq}.
  - Frame k, for k=1..PKT_PAIRS: {buffer[2k-2], buffer[2k-1]}; even byte goes to lane 1, odd byte to lane 2.
  - Optional checksum frame: see Configuration.
- ISSUE: tx_ready=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE:
  - Waits for tx_done.
  - On tx_done, if the frame was the last one, go to ACK_WAIT with timer=0; otherwise frame_idx+1 and go to ISSUE.
- ACK_WAIT:
  - timer increments every cycle.
  - ack_valid && ack_seq==seq: pkt_sent pulse, seq+1, retry=0, wr_idx=0, go to FILL.
  - Else, if timer==TIMEOUT_CYCLES-1 and retry<MAX_RETRY: retry+1, frame_idx=0, go to ISSUE. The same buffer contents and the same seq are resent.
  - Else, if timer==TIMEOUT_CYCLES-1 and retry==MAX_RETRY: pkt_failed pulse, seq+1, retry=0, wr_idx=0, go to FILL.
- Ignored inputs:
  - tx_done outside WAIT_DONE.
  - ack_valid outside ACK_WAIT.
  - Acks with ack_seq != seq.
- Arithmetic and widths:
  - seq wraps from 255 to 0.
  - wr_idx and frame_idx are $clog2 sized and never exceed their last legal value.
- tx_en=1 in ISSUE and WAIT_DONE; 0 otherwise.

## Timing
- Reset values:
  - State FILL, so in_ready=1 and busy=0.
  - tx_ready, tx_en, pkt_sent and pkt_failed are 0.
  - tx_data1, tx_data2 and seq are 0.
  - Buffer contents are don't-care; wr_idx, frame_idx, retry and timer are 0.
- Reset mid-operation discards the packet immediately; there is no drain.
- in_ready, tx_ready, tx_en and busy are Moore outputs decoded from the state register.
- tx_data1 and tx_data2 are registered. They are valid in ISSUE and held through WAIT_DONE.
- The final payload byte is accepted in cycle N; ISSUE of frame 0 is in cycle N+1.
- tx_done in cycle M leads to the next ISSUE in cycle M+1, giving one idle cycle between transmitter frames.
- Exactly TIMEOUT_CYCLES cycles are spent in ACK_WAIT before a retransmission.
- A matching ack in the same cycle as the timeout counts as success.
- pkt_sent and pkt_failed assert in the cycle of the transition out of ACK_WAIT.

## Configuration
- LASER_TX_CHECKSUM_EN defined:
  - One extra frame, frame PKT_PAIRS+1, is sent after the payload: {XOR of all lane-1 payload bytes, XOR of all lane-2 payload bytes}.
  - Both XORs are accumulated while bytes are accepted in FILL and cleared on entry to FILL.
- LASER_TX_CHECKSUM_EN undefined:
  - Frame PKT_PAIRS is the last frame.
  - No XOR logic is present.

## Test plan
Bench parameters: PKT_PAIRS=2, TIMEOUT_CYCLES=16, MAX_RETRY=1.
- Bytes 01,02,03,04 after reset -> frames {A5,00},{01,02},{03,04}; with LASER_TX_CHECKSUM_EN, an extra {02,06}. One tx_ready pulse per frame; each issued the cycle after tx_done.
- ack_valid with ack_seq=00 on the 5th ACK_WAIT cycle -> pkt_sent pulse, seq=01, and in_ready=1 on the next cycle.
- No ack -> after 16 cycles frame {A5,00} is resent with the same payload. After a second 16-cycle timeout -> pkt_failed pulse, seq=01.
- ack_seq=07 while seq=00 -> ignored, timeout path taken. A matching ack on timer=15 -> pkt_sent, no retransmission.
- in_valid held high with 5 bytes offered -> only 4 accepted; the 5th is accepted only after return to FILL. No byte is lost or duplicated.
- reset_n low during WAIT_DONE -> same cycle: tx_en=0, tx_ready=0, seq=00, in_ready=1. The next packet starts with header {A5,00}.

Source files
------------

// File: rtl/laser_tx_sequencer.sv
// Packet sequencer for the dual-lane laser transmitter: buffers a packet, frames it, and sends it with ack/retry.
// Define LASER_TX_CHECKSUM_EN to append an XOR checksum frame after the payload frames.
module laser_tx_sequencer #(
  parameter int         PKT_PAIRS      = 16,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         MAX_RETRY      = 3,
  parameter logic [7:0] SOP            = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tx_data1,
  output logic [7:0] tx_data2,
  output logic       tx_ready,
  input  logic       tx_done,
  output logic       tx_en,
  input  logic       ack_valid,
  input  logic [7:0] ack_seq,
  output logic [7:0] seq,
  output logic       busy,
  output logic       pkt_sent,
  output logic       pkt_failed
);

  localparam int NBYTES = 2 * PKT_PAIRS;
  localparam int WR_W   = $clog2(NBYTES);
`ifdef LASER_TX_CHECKSUM_EN
  localparam int LAST_FRAME = PKT_PAIRS + 1;
`else
  localparam int LAST_FRAME = PKT_PAIRS;
`endif
  localparam int FRAME_W = $clog2(LAST_FRAME + 1);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [WR_W-1:0]    WR_LAST    = WR_W'(NBYTES - 1);
  localparam logic [WR_W-1:0]    WR_ONE     = WR_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(LAST_FRAME);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT_DONE, ACK_WAIT} state_t;

  state_t             state_q, state_d;
  logic [WR_W-1:0]    wr_idx_q, wr_idx_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         tx_data1_q, tx_data1_d;
  logic [7:0]         tx_data2_q, tx_data2_d;
  logic [7:0]         buffer_q [NBYTES];

  logic               accept;
  logic               load_frame;
  logic [FRAME_W-1:0] frame_sel;
  logic [FRAME_W-1:0] pair_idx;
  logic [WR_W-1:0]    lo_idx;
  logic [WR_W-1:0]    hi_idx;

  assign in_ready = (state_q == FILL);
  assign busy     = (state_q != FILL);
  assign tx_ready = (state_q == ISSUE);
  assign tx_en    = (state_q == ISSUE) || (state_q == WAIT_DONE);
  assign tx_data1 = tx_data1_q;
  assign tx_data2 = tx_data2_q;
  assign seq      = seq_q;

  // load_frame/frame_sel select the frame whose bytes are latched as ISSUE is entered
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    frame_idx_d = frame_idx_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    seq_d       = seq_q;
    accept      = 1'b0;
    load_frame  = 1'b0;
    frame_sel   = frame_idx_q;
    pkt_sent    = 1'b0;
    pkt_failed  = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          accept = 1'b1;
          if (wr_idx_q == WR_LAST) begin
            wr_idx_d    = '0;
            frame_idx_d = '0;
            frame_sel   = '0;
            load_frame  = 1'b1;
            state_d     = ISSUE;
          end else begin
            wr_idx_d = wr_idx_q + WR_ONE;
          end
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          if (frame_idx_q == FRAME_LAST) begin
            timer_d = '0;
            state_d = ACK_WAIT;
          end else begin
            frame_idx_d = frame_idx_q + FRAME_ONE;
            frame_sel   = frame_idx_d;
            load_frame  = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ACK_WAIT: begin
        timer_d = timer_q + TIMER_ONE;
        if (ack_valid && (ack_seq == seq_q)) begin
          pkt_sent = 1'b1;
          seq_d    = seq_q + 8'd1;
          retry_d  = '0;
          wr_idx_d = '0;
          state_d  = FILL;
        end else if (timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d     = retry_q + RETRY_ONE;
            frame_idx_d = '0;
            frame_sel   = '0;
            load_frame  = 1'b1;
            state_d     = ISSUE;
          end else begin
            pkt_failed = 1'b1;
            seq_d      = seq_q + 8'd1;
            retry_d    = '0;
            wr_idx_d   = '0;
            state_d    = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifdef LASER_TX_CHECKSUM_EN
  logic [7:0] csum1_q, csum1_d;
  logic [7:0] csum2_q, csum2_d;

  // Leaving ACK_WAIT is the only way back into FILL, so that is where the sums clear
  always_comb begin
    csum1_d = csum1_q;
    csum2_d = csum2_q;
    if (pkt_sent || pkt_failed) begin
      csum1_d = '0;
      csum2_d = '0;
    end else if (accept) begin
      if (wr_idx_q[0]) csum2_d = csum2_q ^ in_data;
      else             csum1_d = csum1_q ^ in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum1_q <= '0;
      csum2_q <= '0;
    end else begin
      csum1_q <= csum1_d;
      csum2_q <= csum2_d;
    end
  end
`endif

  always_comb begin
    pair_idx   = frame_sel - FRAME_ONE;
    lo_idx     = WR_W'({pair_idx, 1'b0});
    hi_idx     = lo_idx | WR_ONE;
    tx_data1_d = tx_data1_q;
    tx_data2_d = tx_data2_q;
    if (load_frame) begin
      if (frame_sel == '0) begin
        tx_data1_d = SOP;
        tx_data2_d = seq_q;
`ifdef LASER_TX_CHECKSUM_EN
      end else if (frame_sel == FRAME_LAST) begin
        tx_data1_d = csum1_q;
        tx_data2_d = csum2_q;
`endif
      end else begin
        tx_data1_d = buffer_q[lo_idx];
        tx_data2_d = buffer_q[hi_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) buffer_q[wr_idx_q] <= in_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      frame_idx_q <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      seq_q       <= '0;
      tx_data1_q  <= '0;
      tx_data2_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      frame_idx_q <= frame_idx_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      seq_q       <= seq_d;
      tx_data1_q  <= tx_data1_d;
      tx_data2_q  <= tx_data2_d;
    end
  end

endmodule

// File: tb/tb_laser_tx_sequencer.sv
// Self-checking bench for laser_tx_sequencer: the bench plays host, transmitter and receiver,
// and predicts every frame and handshake from the packet bytes it has handed over.
module tb_laser_tx_sequencer;
  localparam int         PKT_PAIRS      = 2;
  localparam int         TIMEOUT_CYCLES = 16;
  localparam int         MAX_RETRY      = 1;
  localparam int         NBYTES         = 2 * PKT_PAIRS;
  localparam logic [7:0] SOP            = 8'hA5;
`ifdef LASER_TX_CHECKSUM_EN
  localparam int NFRAMES = PKT_PAIRS + 2;
`else
  localparam int NFRAMES = PKT_PAIRS + 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data1;
  logic [7:0] tx_data2;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_en;
  logic       ack_valid;
  logic [7:0] ack_seq;
  logic [7:0] seq;
  logic       busy;
  logic       pkt_sent;
  logic       pkt_failed;

  int checks = 0;
  int errors = 0;

  // Host/receiver model state: the packet bytes the sequencer has taken, the seq it should be
  // showing, and the byte currently on offer to it
  logic [7:0] modelSeq;
  logic [7:0] pktBytes [NBYTES];
  logic [7:0] headByte;
  logic [7:0] nextBytes [$];
  bit         holdValid;
  bit         noisy;

  laser_tx_sequencer #(
    .PKT_PAIRS(PKT_PAIRS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRY(MAX_RETRY),
    .SOP(SOP)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data1(tx_data1), .tx_data2(tx_data2), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_en(tx_en),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .seq(seq),
    .busy(busy), .pkt_sent(pkt_sent), .pkt_failed(pkt_failed)
  );

  always #5 clock = ~clock;

  // Global bound on run time so a stuck design still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctlBits();
    return {in_ready, busy, tx_en, tx_ready, pkt_sent, pkt_failed};
  endfunction

  function automatic bit coin();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic logic [7:0] freshByte();
    if (nextBytes.size() > 0) return nextBytes.pop_front();
    return 8'($urandom);
  endfunction

  // Expected frame contents straight from the framing rules
  function automatic logic [15:0] frameWord(input int f);
    logic [7:0] x1;
    logic [7:0] x2;
    if (f == 0) return {SOP, modelSeq};
    if (f <= PKT_PAIRS) return {pktBytes[2*f-2], pktBytes[2*f-1]};
    x1 = '0;
    x2 = '0;
    for (int i = 0; i < PKT_PAIRS; i++) begin
      x1 ^= pktBytes[2*i];
      x2 ^= pktBytes[2*i+1];
    end
    return {x1, x2};
  endfunction

  // Host inputs while the sequencer is not filling: the head byte may stay on offer
  task automatic driveQuiet();
    in_valid  = holdValid ? 1'b1 : coin();
    in_data   = headByte;
    ack_valid = noisy && coin();
    ack_seq   = modelSeq;
    tx_done   = 1'b0;
  endtask

  task automatic fillPacket();
    int n = 0;
    int idle = 0;
    while (n < NBYTES) begin
      @(negedge clock);
      checkOutput("fill.ctl", 16'(ctlBits()), 16'(6'b100000));
      checkOutput("fill.seq", 16'(seq), 16'(modelSeq));
      ack_valid = noisy && coin();
      ack_seq   = modelSeq;
      tx_done   = noisy && coin();
      if (holdValid || idle > 4 || $urandom_range(0, 3) != 0) begin
        in_valid    = 1'b1;
        in_data     = headByte;
        pktBytes[n] = headByte;
        n++;
        idle     = 0;
        headByte = freshByte();
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        idle++;
      end
    end
  endtask

  // Plays the transmitter for one full pass of frames; can pull reset in the middle of a frame
  task automatic transmitPacket(input int abortFrame, output bit aborted);
    int d;
    aborted = 1'b0;
    for (int f = 0; f < NFRAMES; f++) begin
      @(negedge clock);
      driveQuiet();
      checkOutput("issue.ctl", 16'(ctlBits()), 16'(6'b011100));
      checkOutput($sformatf("issue.frame%0d", f), {tx_data1, tx_data2}, frameWord(f));
      checkOutput("issue.seq", 16'(seq), 16'(modelSeq));
      d = $urandom_range(0, 3);
      for (int w = 0; w <= d; w++) begin
        @(negedge clock);
        driveQuiet();
        checkOutput("wait.ctl", 16'(ctlBits()), 16'(6'b011000));
        checkOutput("wait.data", {tx_data1, tx_data2}, frameWord(f));
        if (f == abortFrame && w == d) begin
          reset_n = 1'b0;
          #1;
          checkOutput("reset.ctl", 16'(ctlBits()), 16'(6'b100000));
          checkOutput("reset.seq", 16'(seq), 16'h0000);
          checkOutput("reset.data", {tx_data1, tx_data2}, 16'h0000);
          modelSeq = 8'h00;
          @(negedge clock);
          in_valid  = 1'b0;
          ack_valid = 1'b0;
          reset_n   = 1'b1;
          aborted   = 1'b1;
          return;
        end
        tx_done = (w == d);
      end
    end
  endtask

  // Plays the receiver for one ACK_WAIT window; done=0 means a retransmission is expected
  task automatic ackWait(input int ackCycle, input int attempt, output bit done);
    bit expSent;
    bit expFail;
    done = 1'b0;
    for (int t = 0; t < TIMEOUT_CYCLES; t++) begin
      @(negedge clock);
      checkOutput("ack.ctl", 16'({in_ready, busy, tx_en, tx_ready}), 16'(4'b0100));
      checkOutput("ack.seq", 16'(seq), 16'(modelSeq));
      in_valid = holdValid ? 1'b1 : coin();
      in_data  = headByte;
      tx_done  = noisy && coin();
      if (t == ackCycle) begin
        ack_valid = 1'b1;
        ack_seq   = modelSeq;
      end else if (noisy && coin()) begin
        ack_valid = 1'b1;
        ack_seq   = modelSeq + 8'($urandom_range(1, 255));
      end else begin
        ack_valid = 1'b0;
        ack_seq   = modelSeq;
      end
      #1;
      expSent = (t == ackCycle);
      expFail = !expSent && (t == TIMEOUT_CYCLES - 1) && (attempt == MAX_RETRY);
      checkOutput("ack.pkt_sent", 16'(pkt_sent), 16'(expSent));
      checkOutput("ack.pkt_failed", 16'(pkt_failed), 16'(expFail));
      if (expSent || expFail) begin
        modelSeq = modelSeq + 8'd1;
        done = 1'b1;
        return;
      end
    end
  endtask

  // One packet end to end; ackAttempt picks the attempt (or -1 for none) that gets a good ack
  task automatic applyStimulus(input int ackAttempt, input int ackCycle, input int abortFrame);
    bit aborted;
    bit done;
    fillPacket();
    for (int attempt = 0; attempt <= MAX_RETRY; attempt++) begin
      transmitPacket(abortFrame, aborted);
      if (aborted) return;
      ackWait((attempt == ackAttempt) ? ackCycle : -1, attempt, done);
      if (done) return;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    tx_done   = 1'b0;
    ack_valid = 1'b0;
    ack_seq   = 8'h00;
    modelSeq  = 8'h00;
    holdValid = 1'b0;
    noisy     = 1'b0;
    headByte  = 8'h01;
    nextBytes = '{8'h02, 8'h03, 8'h04};
    repeat (2) @(negedge clock);
    checkOutput("reset.ctl", 16'(ctlBits()), 16'(6'b100000));
    checkOutput("reset.seq", 16'(seq), 16'h0000);
    checkOutput("reset.data", {tx_data1, tx_data2}, 16'h0000);
    reset_n = 1'b1;

    // Bytes 01..04, matching ack on the fifth ACK_WAIT cycle
    applyStimulus(0, 4, -1);
    // Never acknowledged: one retransmission, then dropped
    applyStimulus(-1, -1, -1);
    // Stray acks and tx_done around, good ack on the last timer cycle
    noisy = 1'b1;
    applyStimulus(0, TIMEOUT_CYCLES - 1, -1);
    applyStimulus(1, TIMEOUT_CYCLES - 1, -1);
    // Host keeps in_valid high across packets
    holdValid = 1'b1;
    applyStimulus(0, 2, -1);
    applyStimulus(1, 0, -1);
    // Reset while a payload frame is in flight, then a clean packet with seq back at 0
    holdValid = 1'b0;
    noisy     = 1'b0;
    applyStimulus(0, 3, 1);
    applyStimulus(0, 1, -1);

    for (int p = 0; p < 30; p++) begin
      holdValid = coin();
      noisy     = coin();
      applyStimulus($urandom_range(0, MAX_RETRY + 1) - 1,
                    $urandom_range(0, TIMEOUT_CYCLES - 1),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, NFRAMES - 1) : -1);
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
